// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC source, instruction memory port and decode handshake.
// The unit itself uses the slave modport; its environment uses master.
interface fetch_unit_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_misalign_o;

  modport slave (
    input  pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
           instr_misalign_o
  );

  modport master (
    output pc_i, pc_valid_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  pc_ready_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
           instr_misalign_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding word read at a time, results buffered
// with their PC in a DEPTH-entry circular queue toward decode.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready to accept a new PC when the queue has room
// WAIT_GNT  | request held on imem, waiting for grant
// WAIT_RESP | granted, waiting for read data
// DROP      | flushed after grant, waiting to discard the stale response
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RESP, DROP} state_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  ptr_t        head, tail;
  cnt_t        count;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc    [DEPTH];
  logic        q_mis   [DEPTH];

  logic        accept, push, pop, not_empty;
  logic [31:0] push_instr, push_pc;
  logic        push_mis;

  assign not_empty      = (count != '0);
  assign bus.pc_ready_o = (state == IDLE) && !bus.flush_i && (count < FULL) && !rst;
  assign accept         = bus.pc_valid_i && bus.pc_ready_o;

  // Room was reserved when the PC was accepted, so a push never finds the queue full.
  assign push = !bus.flush_i &&
                ((accept && (bus.pc_i[1:0] != 2'b00)) ||
                 ((state == WAIT_RESP) && bus.imem_rvalid_i));
  assign pop  = not_empty && bus.instr_ready_i && !bus.flush_i;

  always_comb begin
    push_instr = '0;
    push_pc    = bus.pc_i;
    push_mis   = 1'b1;
    if (state == WAIT_RESP) begin
      push_instr = bus.imem_rdata_i;
      push_pc    = pc_q;
      push_mis   = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && (bus.pc_i[1:0] == 2'b00)) state_nxt = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (bus.flush_i)         state_nxt = bus.imem_gnt_i ? DROP : IDLE;
        else if (bus.imem_gnt_i) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.flush_i)            state_nxt = bus.imem_rvalid_i ? IDLE : DROP;
        else if (bus.imem_rvalid_i) state_nxt = IDLE;
      end
      DROP: begin
        if (bus.imem_rvalid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pc_q <= bus.pc_i;
      if (bus.flush_i) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + ptr_t'(1);
        if (pop)  head <= head + ptr_t'(1);
        if (push && !pop)      count <= count + cnt_t'(1);
        else if (pop && !push) count <= count - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_instr[tail] <= push_instr;
      q_pc[tail]    <= push_pc;
      q_mis[tail]   <= push_mis;
    end
  end

  assign bus.imem_req_o       = (state == WAIT_GNT);
  assign bus.imem_addr_o      = {pc_q[31:2], 2'b00};
  assign bus.instr_valid_o    = not_empty;
  assign bus.instr_o          = not_empty ? q_instr[head] : '0;
  assign bus.instr_pc_o       = not_empty ? q_pc[head]    : '0;
  assign bus.instr_misalign_o = not_empty ? q_mis[head]   : 1'b0;

endmodule
